// File: rtl/riscv_apu_pkg.sv
// Shared APU definitions: widths and the write-back buffer entry layout.
package riscv_apu_pkg;

  localparam int unsigned APU_NDSFLAGS       = 5;
  localparam int unsigned REGFILE_ADDR_WIDTH = 6;
  localparam int unsigned APU_DATA_WIDTH     = 32;

  typedef struct packed {
    logic [REGFILE_ADDR_WIDTH-1:0] waddr;
    logic [APU_DATA_WIDTH-1:0]     result;
    logic [APU_NDSFLAGS-1:0]       flags;
  } apu_wb_entry_t;

endpackage

// File: rtl/riscv_apu_wb_fifo.sv
// In-order storage for pending APU results: circular buffer with per-entry valid bits.
module riscv_apu_wb_fifo
  import riscv_apu_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  apu_wb_entry_t                 push_entry_i,
  input  logic                          pop_i,
  output apu_wb_entry_t                 head_o,
  output logic [PTR_W-1:0]              rd_ptr_o,
  output logic [CNT_W-1:0]              count_o,
  output logic [DEPTH-1:0]              valid_o,
  output logic [REGFILE_ADDR_WIDTH-1:0] waddr_o [DEPTH]
);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] valid_q;
  apu_wb_entry_t    mem_q [DEPTH];

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // Clear before set: a full buffer pops and refills the same slot.
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
      end
      if (push_i) begin
        valid_q[wr_ptr_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  always_comb begin
    for (int e = 0; e < int'(DEPTH); e++) begin
      waddr_o[e] = mem_q[e].waddr;
    end
  end

  assign head_o   = mem_q[rd_ptr_q];
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/riscv_apu_wb_buffer.sv
// APU result write-back buffer: zero-latency bypass to RF port B, otherwise queues
// results until the port is free, and flags decode-stage hazards on queued entries.
module riscv_apu_wb_buffer
  import riscv_apu_pkg::*;
#(
  parameter  int unsigned DEPTH       = 2,
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned FLAGS_WIDTH = 5,
  parameter  int unsigned ADDR_WIDTH  = 6,
  localparam int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        apu_valid_i,
  input  logic [DATA_WIDTH-1:0]       apu_result_i,
  input  logic [FLAGS_WIDTH-1:0]      apu_flags_i,
  input  logic [ADDR_WIDTH-1:0]       apu_waddr_i,
  output logic                        apu_ready_o,
  input  logic                        wb_port_busy_i,
  output logic                        wb_we_o,
  output logic [ADDR_WIDTH-1:0]       wb_waddr_o,
  output logic [DATA_WIDTH-1:0]       wb_wdata_o,
  output logic                        fflags_we_o,
  output logic [FLAGS_WIDTH-1:0]      fflags_o,
  input  logic [2:0][ADDR_WIDTH-1:0]  read_regs_i,
  input  logic [2:0]                  read_regs_valid_i,
  output logic                        pend_dep_o,
  output logic [CNT_W-1:0]            count_o,
  output logic                        overflow_o
);

  apu_wb_entry_t                 push_entry;
  apu_wb_entry_t                 head;
  logic [PTR_W-1:0]              rd_ptr;
  logic [CNT_W-1:0]              fifo_count;
  logic [DEPTH-1:0]              fifo_valid;
  logic [REGFILE_ADDR_WIDTH-1:0] entry_waddr [DEPTH];
  logic                          empty, bypass, pop, push;
  logic                          overflow_q;

  assign push_entry = '{waddr:  REGFILE_ADDR_WIDTH'(apu_waddr_i),
                        result: APU_DATA_WIDTH'(apu_result_i),
                        flags:  APU_NDSFLAGS'(apu_flags_i)};

  // Head of queue has the port first; a new response then queues behind it.
  assign empty       = (fifo_count == '0);
  assign apu_ready_o = (fifo_count < CNT_W'(DEPTH)) | ~wb_port_busy_i;
  assign bypass      = rst_ni & empty & apu_valid_i & ~wb_port_busy_i;
  assign pop         = rst_ni & ~empty & ~wb_port_busy_i;
  assign push        = rst_ni & apu_valid_i & apu_ready_o & ~bypass;

  riscv_apu_wb_fifo #(
    .DEPTH (DEPTH)
  ) i_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .rd_ptr_o     (rd_ptr),
    .count_o      (fifo_count),
    .valid_o      (fifo_valid),
    .waddr_o      (entry_waddr)
  );

  // Port B drive; fields are zeroed whenever no write happens.
  always_comb begin
    wb_we_o    = 1'b0;
    wb_waddr_o = '0;
    wb_wdata_o = '0;
    fflags_o   = '0;
    if (pop) begin
      wb_we_o    = 1'b1;
      wb_waddr_o = ADDR_WIDTH'(head.waddr);
      wb_wdata_o = DATA_WIDTH'(head.result);
      fflags_o   = FLAGS_WIDTH'(head.flags);
    end else if (bypass) begin
      wb_we_o    = 1'b1;
      wb_waddr_o = apu_waddr_i;
      wb_wdata_o = apu_result_i;
      fflags_o   = apu_flags_i;
    end
  end

  assign fflags_we_o = wb_we_o;

  // The entry retiring this cycle is already visible to decode via the RF write.
  always_comb begin
    pend_dep_o = 1'b0;
    for (int e = 0; e < int'(DEPTH); e++) begin
      if (fifo_valid[e] && !(pop && (rd_ptr == PTR_W'(e)))) begin
        for (int i = 0; i < 3; i++) begin
          if (read_regs_valid_i[i] && (read_regs_i[i] == ADDR_WIDTH'(entry_waddr[e]))) begin
            pend_dep_o = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
    end else if (apu_valid_i && !apu_ready_o) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;
  assign count_o    = fifo_count;

endmodule

// File: doc/riscv_apu_wb_buffer.md
RISCV_APU_WB_BUFFER -- requirements
Module: riscv_apu_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of result entries held (≥1).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, result width.
REQ-003 SHALL have parameter FLAGS_WIDTH, default 5, FP flag width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 6, register-file address width.
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 apu_valid_i  in  1  APU response valid.
REQ-008 apu_result_i  in  DATA_WIDTH  APU result.
REQ-009 apu_flags_i  in  FLAGS_WIDTH  APU flags.
REQ-010 apu_waddr_i  in  ADDR_WIDTH  destination register from the APU dispatcher.
REQ-011 apu_ready_o  out  1  response channel ready; replaces the dispatcher's constant-1 ready.
REQ-012 wb_port_busy_i  in  1  register-file write port B claimed this cycle by a higher-priority source (LSU).
REQ-013 wb_we_o  out  1  write enable, port B.
REQ-014 wb_waddr_o  out  ADDR_WIDTH  write address.
REQ-015 wb_wdata_o  out  DATA_WIDTH  write data.
REQ-016 fflags_we_o  out  1  flag-update strobe to the CSR block, equal to wb_we_o.
REQ-017 fflags_o  out  FLAGS_WIDTH  flags accompanying the write.
REQ-018 read_regs_i  in  3xADDR_WIDTH  decode-stage source registers.
REQ-019 read_regs_valid_i  in  3  source-register valid bits.
REQ-020 pend_dep_o  out  1  a valid source register matches a buffered, unwritten entry.
REQ-021 count_o  out  $clog2(DEPTH+1)  occupancy.
REQ-022 overflow_o  out  1  sticky error: a response arrived while not ready.

Function
REQ-023 SHALL be an in-order FIFO of {waddr, result, flags}; results SHALL retire in arrival order.
REQ-024 Bypass: if count==0, apu_valid_i=1 and wb_port_busy_i=0, SHALL drive wb_we_o=1 with the input fields in the same cycle (0 latency) and SHALL NOT push.
REQ-025 Pop: if count>0 and wb_port_busy_i=0, SHALL drive the head entry on wb_* with wb_we_o=1 and advance the read pointer at the edge.
REQ-026 Priority: the head entry SHALL win over a new input, and a new input arriving in that cycle SHALL be pushed.
REQ-027 Push: apu_valid_i=1 without a bypass SHALL write the tail entry and advance the write pointer.
REQ-028 Simultaneous push and pop SHALL leave count unchanged, including at count==DEPTH.
REQ-029 apu_ready_o SHALL be (count<DEPTH) | !wb_port_busy_i, combinational.
REQ-030 If apu_valid_i & !apu_ready_o: the data SHALL be dropped, overflow_o SHALL set at the edge and hold until reset, and count SHALL stay at DEPTH.
REQ-031 Pointers SHALL wrap from DEPTH-1 to 0; non-power-of-two DEPTH SHALL be supported.
REQ-032 If wb_we_o=0, wb_waddr_o, wb_wdata_o and fflags_o SHALL be 0.
REQ-033 pend_dep_o SHALL be the OR, over i and over valid entries not being written this cycle, of (read_regs_i[i]==entry.waddr) & read_regs_valid_i[i].

Reset
REQ-034 On rst_ni=0, asynchronously: count, pointers and overflow_o SHALL be 0, and all entry valid bits SHALL be cleared.
REQ-035 During reset: wb_we_o, fflags_we_o and pend_dep_o SHALL be 0, and apu_ready_o SHALL be 1.
REQ-036 Reset asserted mid-operation SHALL discard buffered entries without writing them.

Structure
REQ-037 The shared package riscv_apu_pkg SHALL hold APU_NDSFLAGS (flags width), REGFILE_ADDR_WIDTH and the entry struct type.
REQ-038 The storage and pointer logic SHALL be one sub-module, riscv_apu_wb_fifo; dependency matching and bypass logic SHALL stay in the top.

Verification
REQ-039 Bypass: count=0, busy=0, valid with waddr=5, data=0x1234 -> wb_we_o=1, waddr 5, data 0x1234 same cycle; count stays 0.
REQ-040 Fill and drain: busy=1, two valids (waddr 3 then 4) -> count=2, ready=0; busy=0 -> writes 3 then 4 on consecutive cycles; count 2→1→0.
REQ-041 Full with pop: count=2, busy=0, valid with waddr 7 -> ready=1; head written; count stays 2; 7 retires after the older entry.
REQ-042 Overflow: count=2, busy=1, valid -> ready=0; overflow_o=1 next cycle and sticky; count=2; the dropped data is never written.
REQ-043 Dependency: entry waddr=9 buffered, busy=1, read_regs_i[1]=9, valid bit 1 set -> pend_dep_o=1; busy=0 that cycle -> pend_dep_o=0.
REQ-044 Reset mid-op: count=2, assert rst_ni=0 -> count 0 and wb_we_o=0 immediately; after release, no stale writes occur.
